fir_folded_core: RTL and testbench



---
 rtl/fir_folded_core.sv | 185 ++++++++++++++++++
 tb/tb_fir_folded_core.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_folded_core.sv
// Time-multiplexed FIR: NUM_LANES MAC lanes each walk TAPS_PER_LANE taps per input sample.
// Define FIR_SAT_EN to saturate the output to OUT_W bits; by default it wraps.
module fir_folded_core #(
    parameter int DATA_W        = 3,
    parameter int COEFF_W       = 16,
    parameter int OUT_W         = 16,
    parameter int NUM_LANES     = 4,
    parameter int TAPS_PER_LANE = 10,
    parameter int OUT_SHIFT     = 0
) (
    input  logic                                         iClk12M,
    input  logic                                         iRsn,
    input  logic                                         iEnSample600k,
    input  logic                                         iCoeffUpdateFlag,
    input  logic                                         iCoeffWrEn,
    input  logic [$clog2(NUM_LANES*TAPS_PER_LANE)-1:0]   iAddrRam,
    input  logic signed [COEFF_W-1:0]                    iWrDtRam,
    input  logic [$clog2(NUM_LANES*TAPS_PER_LANE+1)-1:0] iNumOfCoeff,
    input  logic signed [DATA_W-1:0]                     iFirIn,
    output logic signed [OUT_W-1:0]                      oFirOut,
    output logic                                         oValid,
    output logic                                         oBusy,
    output logic                                         oOverrun
);

    localparam int NTAPS  = NUM_LANES * TAPS_PER_LANE;
    localparam int ADDR_W = $clog2(NTAPS);
    localparam int NUM_W  = $clog2(NTAPS + 1);
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int ACC_W  = PROD_W + $clog2(NTAPS);
    localparam int CNT_W  = (TAPS_PER_LANE > 1) ? $clog2(TAPS_PER_LANE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        SUM  = 2'd2,
        DONE = 2'd3
    } stateType;

    stateType                  state;
    stateType                  nextState;

    logic signed [DATA_W-1:0]  delayLine [NTAPS];
    logic signed [COEFF_W-1:0] coeffMem  [NTAPS];
    logic signed [ACC_W-1:0]   laneAcc   [NUM_LANES];
    logic signed [ACC_W-1:0]   total;
    logic [CNT_W-1:0]          cnt;
    logic [NUM_W-1:0]          numActive;

    logic [ADDR_W-1:0]         tapAddr   [NUM_LANES];
    logic signed [PROD_W-1:0]  laneProd  [NUM_LANES];
    logic signed [ACC_W-1:0]   laneSum;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [OUT_W-1:0]   outNext;

    logic                      startStrobe;
    logic                      dropStrobe;
    logic                      abortRun;
    logic                      coeffWr;

    // A strobe in update mode is neither a start nor an overrun.
    assign startStrobe = (state == IDLE) && iEnSample600k && !iCoeffUpdateFlag;
    assign dropStrobe  = (state != IDLE) && iEnSample600k && !iCoeffUpdateFlag;
    assign abortRun    = ((state == MAC) || (state == SUM)) && iCoeffUpdateFlag;
    assign coeffWr     = iCoeffUpdateFlag && iCoeffWrEn && (32'(iAddrRam) < NTAPS);
    assign oBusy       = (state == MAC) || (state == SUM);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every output of a combinational block is given a default before
    // the case statement, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (startStrobe) nextState = MAC;
            end
            MAC: begin
                if (abortRun) begin
                    nextState = IDLE;
                end else if (cnt == CNT_W'(TAPS_PER_LANE - 1)) begin
                    nextState = SUM;
                end
            end
            SUM:     nextState = abortRun ? IDLE : DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Lane l handles tap l*TAPS_PER_LANE+cnt; taps beyond the active count are masked.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            tapAddr[l]  = ADDR_W'(l * TAPS_PER_LANE) + ADDR_W'(cnt);
            laneProd[l] = '0;
            if (32'(tapAddr[l]) < 32'(numActive)) begin
                laneProd[l] = coeffMem[tapAddr[l]] * delayLine[tapAddr[l]];
            end
        end
    end

    always_comb begin
        laneSum = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            laneSum = laneSum + laneAcc[l];
        end
    end

    assign shifted = total >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        outNext = OUT_W'(shifted);
        if (shifted > SAT_MAX) begin
            outNext = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            outNext = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end
`else
    assign outNext = OUT_W'(shifted);
`endif

    // Delay line, lane accumulators and the final total.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int i = 0; i < NTAPS; i++) delayLine[i] <= '0;
            for (int l = 0; l < NUM_LANES; l++) laneAcc[l] <= '0;
            total     <= '0;
            cnt       <= '0;
            numActive <= '0;
        end else begin
            if (startStrobe) begin
                delayLine[0] <= iFirIn;
                for (int i = NTAPS - 1; i > 0; i--) delayLine[i] <= delayLine[i-1];
                for (int l = 0; l < NUM_LANES; l++) laneAcc[l] <= '0;
                cnt       <= '0;
                numActive <= (32'(iNumOfCoeff) > NTAPS) ? NUM_W'(NTAPS) : iNumOfCoeff;
            end
            if (state == MAC) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    laneAcc[l] <= laneAcc[l] + ACC_W'(laneProd[l]);
                end
                cnt <= cnt + 1'b1;
            end
            if (state == SUM) begin
                total <= laneSum;
            end
        end
    end

    // NOTE: the coefficient file is reset like ordinary flops because a reset
    // must leave every tap at zero; this rules out mapping it to a RAM macro.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int i = 0; i < NTAPS; i++) coeffMem[i] <= '0;
        end else if (coeffWr) begin
            coeffMem[iAddrRam] <= iWrDtRam;
        end
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            oFirOut  <= '0;
            oValid   <= 1'b0;
            oOverrun <= 1'b0;
        end else begin
            oValid <= (state == DONE);
            if (state == DONE) oFirOut <= outNext;
            if (dropStrobe) oOverrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_folded_core.sv
// Directed bench for fir_folded_core: impulse, truncation, signed math, abort,
// overrun, zero taps, output limiting and mid-run reset.
module tb_fir_folded_core;

    localparam int NTAPS = 40;
    localparam int LAT   = 12;

    logic               clk = 1'b0;
    logic               rsn;
    logic               enSample;
    logic               coeffFlag;
    logic               coeffWrEn;
    logic [5:0]         addrRam;
    logic signed [15:0] wrDt;
    logic [5:0]         numCoeff;
    logic signed [2:0]  firIn;
    logic signed [15:0] firOut;
    logic               valid;
    logic               busy;
    logic               overrun;

    int assertCount = 0;
    int failCount   = 0;

    fir_folded_core dut (
        .iClk12M          (clk),
        .iRsn             (rsn),
        .iEnSample600k    (enSample),
        .iCoeffUpdateFlag (coeffFlag),
        .iCoeffWrEn       (coeffWrEn),
        .iAddrRam         (addrRam),
        .iWrDtRam         (wrDt),
        .iNumOfCoeff      (numCoeff),
        .iFirIn           (firIn),
        .oFirOut          (firOut),
        .oValid           (valid),
        .oBusy            (busy),
        .oOverrun         (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic writeCoeff(input int addr, input int data);
        @(posedge clk); #1;
        coeffWrEn = 1'b1;
        addrRam   = 6'(addr);
        wrDt      = 16'(data);
        @(posedge clk); #1;
        coeffWrEn = 1'b0;
    endtask

    // Strobe one sample, wait (bounded) for oValid, check latency and optionally value.
    task automatic runSample(input int x, input int expVal, input bit checkValue, input string tag);
        int lat;
        @(posedge clk); #1;
        enSample = 1'b1;
        firIn    = 3'(x);
        @(posedge clk); #1;
        enSample = 1'b0;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (valid) begin
                lat = c;
                break;
            end
        end
        check({tag, "_lat"}, lat, LAT);
        if (checkValue) check(tag, firOut, expVal);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        int lat;
        logic signed [15:0] limitExp;

        rsn       = 1'b0;
        enSample  = 1'b0;
        coeffFlag = 1'b0;
        coeffWrEn = 1'b0;
        addrRam   = '0;
        wrDt      = '0;
        numCoeff  = 6'd40;
        firIn     = '0;
        #23;
        check("rst_out", firOut, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rsn = 1'b1;

        // Impulse response with coeff[k] = k+1.
        @(posedge clk); #1; coeffFlag = 1'b1;
        for (int k = 0; k < NTAPS; k++) writeCoeff(k, k + 1);
        @(posedge clk); #1; coeffFlag = 1'b0;
        for (int k = 0; k <= NTAPS; k++) begin
            runSample((k == 0) ? 1 : 0, (k < NTAPS) ? k + 1 : 0, 1'b1, $sformatf("imp%0d", k));
        end

        // Active-tap truncation: N=5, constant input 1.
        numCoeff = 6'd5;
        runSample(1, 1, 1'b1, "trunc0");
        runSample(1, 3, 1'b1, "trunc1");
        runSample(1, 6, 1'b1, "trunc2");
        runSample(1, 10, 1'b1, "trunc3");
        runSample(1, 15, 1'b1, "trunc4");
        runSample(1, 15, 1'b1, "trunc5");
        runSample(1, 15, 1'b1, "trunc6");

        // Negative math: coeff[0]=-3, coeff[1]=0, N=2.
        @(posedge clk); #1; coeffFlag = 1'b1;
        writeCoeff(0, -3);
        writeCoeff(1, 0);
        @(posedge clk); #1; coeffFlag = 1'b0;
        numCoeff = 6'd2;
        runSample(-4, 12, 1'b1, "neg0");
        runSample(0, 0, 1'b1, "neg1");

        // Abort: establish a prior output of 12, then raise the flag mid-MAC.
        runSample(-4, 12, 1'b1, "abPrior");
        @(posedge clk); #1;
        enSample = 1'b1;
        firIn    = 3'sd0;
        @(posedge clk); #1;
        enSample = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abBusyPre", busy, 1);
        coeffFlag = 1'b1;
        @(posedge clk); #1;
        check("abBusyPost", busy, 0);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (valid) seen = 1;
        end
        writeCoeff(2, 5);
        @(posedge clk); #1;
        enSample = 1'b1;
        firIn    = 3'sd3;
        @(posedge clk); #1;
        enSample = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (valid) seen = 1;
        end
        check("abNoValid", seen, 0);
        check("abHold", firOut, 12);
        check("abNoOverrun", overrun, 0);
        @(posedge clk); #1; coeffFlag = 1'b0;
        numCoeff = 6'd3;
        runSample(0, -20, 1'b1, "abResume");

        // Write with the flag low must be ignored.
        writeCoeff(0, 7);

        // Overrun: second strobe 5 cycles after the first is dropped.
        numCoeff = 6'd4;
        @(posedge clk); #1;
        enSample = 1'b1;
        firIn    = 3'sd1;
        @(posedge clk); #1;
        enSample = 1'b0;
        lat = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            enSample = (c == 4);
            firIn    = (c == 4) ? 3'sd2 : 3'sd0;
            if (valid) begin
                lat = c;
                break;
            end
        end
        enSample = 1'b0;
        check("ovr_lat", lat, LAT);
        check("ovr_out", firOut, -19);
        check("ovr_flag", overrun, 1);
        runSample(0, 0, 1'b1, "ovrNoShift");
        check("ovr_sticky", overrun, 1);

        // Zero active taps still produces a valid zero.
        numCoeff = 6'd0;
        runSample(3, 0, 1'b1, "zeroTaps");

        // Output limiting: all coeff max, constant input 3 over all taps.
        @(posedge clk); #1; coeffFlag = 1'b1;
        for (int k = 0; k < NTAPS; k++) writeCoeff(k, 32767);
        @(posedge clk); #1; coeffFlag = 1'b0;
        numCoeff = 6'd40;
`ifdef FIR_SAT_EN
        limitExp = 16'sd32767;
`else
        limitExp = 16'(40 * 3 * 32767);
`endif
        for (int i = 0; i < NTAPS; i++) begin
            runSample(3, limitExp, (i == NTAPS - 1), $sformatf("limit%0d", i));
        end

        // Reset mid-operation clears everything, including coefficients.
        @(posedge clk); #1;
        enSample = 1'b1;
        firIn    = 3'sd3;
        @(posedge clk); #1;
        enSample = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rsn = 1'b0;
        #1;
        check("midRst_busy", busy, 0);
        check("midRst_out", firOut, 0);
        check("midRst_overrun", overrun, 0);
        check("midRst_valid", valid, 0);
        @(posedge clk); #1;
        rsn = 1'b1;
        runSample(3, 0, 1'b1, "postRst");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
